// File: rtl/calc_stream_engine_pkg.sv
// Shared types and defaults for the streaming calculator: arithmetic modes,
// engine FSM states and the memory-word width derivation.
package calculator_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;
    localparam int RD_LAT_DEF = 1;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ADD    = 2'b00,
        SUB    = 2'b01,
        SATADD = 2'b10,
        RSVD   = 2'b11
    } calc_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_WAIT,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } calc_state_e;

    // One memory word carries two operands (or two packed results).
    function automatic int mem_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/calc_stream_engine_if.sv
// Control handshake plus SRAM read/write ports of the streaming calculator.
// master = engine side, slave = top level / SRAM side.
interface calc_stream_if
    import calculator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int MEM_W = mem_w(DATA_W);

    logic              start_i;
    logic [1:0]        mode_i;
    logic [ADDR_W-1:0] read_start_addr;
    logic [ADDR_W-1:0] read_end_addr;
    logic [ADDR_W-1:0] write_start_addr;
    logic [ADDR_W-1:0] write_end_addr;

    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [MEM_W-1:0]  rd_data_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [MEM_W-1:0]  wr_data_o;

    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [CNT_W-1:0]  ovf_cnt_o;

    modport master (
        input  start_i, mode_i, read_start_addr, read_end_addr,
               write_start_addr, write_end_addr, rd_data_i,
        output rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
               busy_o, done_o, err_o, ovf_cnt_o
    );

    modport slave (
        output start_i, mode_i, read_start_addr, read_end_addr,
               write_start_addr, write_end_addr, rd_data_i,
        input  rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
               busy_o, done_o, err_o, ovf_cnt_o
    );

endinterface

// File: rtl/calc_stream_engine_alu.sv
// Combinational arithmetic unit: add, subtract and unsigned saturating add,
// with a single overflow flag (carry-out or borrow).
module calc_alu
    import calculator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  calc_mode_e        mode,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    // The reserved mode encoding behaves as a plain add.
    always_comb begin
        result = sum[DATA_W-1:0];
        ovf    = sum[DATA_W];
        case (mode)
            SUB: begin
                result = a - b;
                ovf    = (a < b);
            end
            SATADD: begin
                if (sum[DATA_W]) result = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_stream_engine.sv
// Streams operand words from SRAM, runs them through calc_alu, packs two
// results per word and writes them back; start/busy/done handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; latches configuration on start
// ST_CHECK | validates address ranges, aborts with err on inverted ranges
// ST_READ  | one-cycle read strobe at the current read pointer
// ST_WAIT  | down-counts the SRAM read latency, captures the read word
// ST_CALC  | computes one result into the pack buffer half
// ST_WRITE | one-cycle write strobe of the packed word
// ST_DONE  | one-cycle done pulse, then back to idle
module calc_stream_engine
    import calculator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic          clk,
    input logic          rst,
    calc_stream_if.master bus
);

    localparam int MEM_W  = mem_w(DATA_W);
    localparam int WAIT_W = 3;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT - 1);

    calc_state_e       state;
    calc_mode_e        mode_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_end;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_end;
    logic [WAIT_W-1:0] wait_cnt;
    logic [MEM_W-1:0]  op_word;
    logic [MEM_W-1:0]  pack;
    logic [MEM_W-1:0]  new_pack;
    logic              half;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_W-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  ovf_cnt;

    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic              last_read;

    calc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (op_word[DATA_W-1:0]),
        .b      (op_word[MEM_W-1:DATA_W]),
        .mode   (mode_q),
        .result (alu_res),
        .ovf    (alu_ovf)
    );

    assign last_read = (rd_ptr == rd_end);

    always_comb begin
        new_pack = pack;
        if (!half) new_pack[DATA_W-1:0]     = alu_res;
        else       new_pack[MEM_W-1:DATA_W] = alu_res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            mode_q   <= ADD;
            rd_ptr   <= '0;
            rd_end   <= '0;
            wr_ptr   <= '0;
            wr_end   <= '0;
            wait_cnt <= '0;
            op_word  <= '0;
            pack     <= '0;
            half     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        mode_q  <= calc_mode_e'(bus.mode_i);
                        rd_ptr  <= bus.read_start_addr;
                        rd_end  <= bus.read_end_addr;
                        wr_ptr  <= bus.write_start_addr;
                        wr_end  <= bus.write_end_addr;
                        err     <= 1'b0;
                        ovf_cnt <= '0;
                        pack    <= '0;
                        half    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (rd_end < rd_ptr || wr_end < wr_ptr) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= rd_ptr;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        op_word <= bus.rd_data_i;
                        state   <= ST_CALC;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_CALC: begin
                    half <= ~half;
                    if (alu_ovf && ovf_cnt != {CNT_W{1'b1}}) ovf_cnt <= ovf_cnt + 1'b1;
                    // The buffer is cleared as it is handed to the write so an
                    // odd final result goes out with a zero high half.
                    if (half || last_read) begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_ptr;
                        wr_data <= new_pack;
                        pack    <= '0;
                        state   <= ST_WRITE;
                    end else begin
                        pack    <= new_pack;
                        rd_ptr  <= rd_ptr + 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= rd_ptr + 1'b1;
                        state   <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (!last_read && wr_ptr < wr_end) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        wr_ptr  <= wr_ptr + 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= rd_ptr + 1'b1;
                        state   <= ST_READ;
                    end else begin
                        // Operands left over with no result space is an error.
                        if (!last_read) err <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en_o   = rd_en;
    assign bus.rd_addr_o = rd_addr;
    assign bus.wr_en_o   = wr_en;
    assign bus.wr_addr_o = wr_addr;
    assign bus.wr_data_o = wr_data;
    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.err_o     = err;
    assign bus.ovf_cnt_o = ovf_cnt;

endmodule

// File: tb/tb_calc_stream_engine.sv
// Directed bench for calc_stream_engine: one instance with read latency 1,
// one with read latency 3, sharing a behavioural SRAM image.
module tb_calc_stream_engine;
    import calculator_pkg::*;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int CW = 16;
    localparam int MW = 64;
    localparam logic [MW-1:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic          start1 = 1'b0;
    logic          start3 = 1'b0;
    logic [1:0]    mode_v = 2'b00;
    logic [AW-1:0] rs_v = '0, re_v = '0, ws_v = '0, we_v = '0;

    calc_stream_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus1();
    calc_stream_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus3();

    calc_stream_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.master));
    calc_stream_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .CNT_W(CW)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.master));

    assign bus1.start_i = start1;          assign bus3.start_i = start3;
    assign bus1.mode_i = mode_v;           assign bus3.mode_i = mode_v;
    assign bus1.read_start_addr = rs_v;    assign bus3.read_start_addr = rs_v;
    assign bus1.read_end_addr = re_v;      assign bus3.read_end_addr = re_v;
    assign bus1.write_start_addr = ws_v;   assign bus3.write_start_addr = ws_v;
    assign bus1.write_end_addr = we_v;     assign bus3.write_end_addr = we_v;

    // SRAM model: data is valid only in the exact cycle RD_LAT after the strobe.
    logic [MW-1:0] mem [0:511];
    logic [MW-1:0] d1;
    logic          v1 = 1'b0;
    logic [MW-1:0] d3 [3];
    logic          v3 [3];
    initial for (int i = 0; i < 3; i++) v3[i] = 1'b0;

    always @(posedge clk) begin
        d1 <= mem[bus1.rd_addr_o];
        v1 <= bus1.rd_en_o;
        d3[0] <= mem[bus3.rd_addr_o];
        v3[0] <= bus3.rd_en_o;
        d3[1] <= d3[0]; v3[1] <= v3[0];
        d3[2] <= d3[1]; v3[2] <= v3[1];
    end
    assign bus1.rd_data_i = v1 ? d1 : JUNK;
    assign bus3.rd_data_i = v3[2] ? d3[2] : JUNK;

    int rd_cnt1 = 0, wr_cnt1 = 0, done_cnt1 = 0;
    int rd_cnt3 = 0, wr_cnt3 = 0, done_cnt3 = 0;
    logic [AW-1:0] waddr1 [256];
    logic [MW-1:0] wdata1 [256];
    logic [AW-1:0] waddr3 [256];
    logic [MW-1:0] wdata3 [256];

    always @(negedge clk) begin
        if (bus1.rd_en_o) rd_cnt1++;
        if (bus1.wr_en_o) begin
            waddr1[wr_cnt1 % 256] = bus1.wr_addr_o;
            wdata1[wr_cnt1 % 256] = bus1.wr_data_o;
            wr_cnt1++;
        end
        if (bus1.done_o) done_cnt1++;
        if (bus3.rd_en_o) rd_cnt3++;
        if (bus3.wr_en_o) begin
            waddr3[wr_cnt3 % 256] = bus3.wr_addr_o;
            wdata3[wr_cnt3 % 256] = bus3.wr_data_o;
            wr_cnt3++;
        end
        if (bus3.done_o) done_cnt3++;
    end

    int lat, rd_b, wr_b, dn_b;
    bit tmo;

    task automatic snap(input int inst);
        rd_b = (inst == 3) ? rd_cnt3 : rd_cnt1;
        wr_b = (inst == 3) ? wr_cnt3 : wr_cnt1;
        dn_b = (inst == 3) ? done_cnt3 : done_cnt1;
    endtask

    // Starts one run and waits for done; lat = negedges from start to done.
    task automatic run(input int inst, input logic [1:0] m, input logic [AW-1:0] rs,
                       input logic [AW-1:0] re, input logic [AW-1:0] ws, input logic [AW-1:0] we);
        snap(inst);
        @(negedge clk);
        mode_v = m; rs_v = rs; re_v = re; ws_v = ws; we_v = we;
        if (inst == 3) start3 = 1'b1; else start1 = 1'b1;
        lat = 0; tmo = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) begin start1 = 1'b0; start3 = 1'b0; end
            if ((inst == 3) ? bus3.done_o : bus1.done_o) begin lat = i; tmo = 1'b0; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.rd_en_o, bus1.wr_en_o, bus1.busy_o, bus1.done_o, bus1.err_o, bus1.ovf_cnt_o,
             bus1.rd_addr_o, bus1.wr_addr_o, bus1.wr_data_o} !== '0) begin
            failures++; $display("FAIL reset_outputs: got nonzero outputs, required all zero");
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_add;
        mem[0] = {32'd2, 32'd3};
        mem[1] = {32'd5, 32'd7};
        run(1, 2'b00, 9'd0, 9'd1, 9'd256, 9'd256);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL add_timeout: done never seen"); end
        checks++; if (wr_cnt1 - wr_b !== 1) begin failures++; $display("FAIL add_wr_count: got %0d required 1", wr_cnt1 - wr_b); end
        checks++; if (waddr1[wr_b % 256] !== 9'd256) begin failures++; $display("FAIL add_wr_addr: got %0d required 256", waddr1[wr_b % 256]); end
        checks++; if (wdata1[wr_b % 256] !== {32'd12, 32'd5}) begin failures++; $display("FAIL add_wr_data: got %h required %h", wdata1[wr_b % 256], {32'd12, 32'd5}); end
        checks++; if (done_cnt1 - dn_b !== 1) begin failures++; $display("FAIL add_done_pulse: got %0d cycles required 1", done_cnt1 - dn_b); end
        checks++; if (bus1.err_o !== 1'b0) begin failures++; $display("FAIL add_err: got %b required 0", bus1.err_o); end
        checks++; if (bus1.ovf_cnt_o !== 16'd0) begin failures++; $display("FAIL add_ovf: got %0d required 0", bus1.ovf_cnt_o); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL add_latency: got %0d required 9", lat); end
        checks++; if (rd_cnt1 - rd_b !== 2) begin failures++; $display("FAIL add_rd_count: got %0d required 2", rd_cnt1 - rd_b); end
        checks++; if (bus1.busy_o !== 1'b0) begin failures++; $display("FAIL add_busy_after: got %b required 0", bus1.busy_o); end
    endtask

    task automatic test_sub_odd;
        mem[10] = {32'd1, 32'd4};
        mem[11] = {32'd2, 32'd9};
        mem[12] = {32'd10, 32'd3};
        run(1, 2'b01, 9'd10, 9'd12, 9'd260, 9'd261);
        checks++; if (wr_cnt1 - wr_b !== 2) begin failures++; $display("FAIL sub_wr_count: got %0d required 2", wr_cnt1 - wr_b); end
        checks++; if (waddr1[wr_b % 256] !== 9'd260) begin failures++; $display("FAIL sub_addr0: got %0d required 260", waddr1[wr_b % 256]); end
        checks++; if (wdata1[wr_b % 256] !== {32'd7, 32'd3}) begin failures++; $display("FAIL sub_data0: got %h required %h", wdata1[wr_b % 256], {32'd7, 32'd3}); end
        checks++; if (waddr1[(wr_b + 1) % 256] !== 9'd261) begin failures++; $display("FAIL sub_addr1: got %0d required 261", waddr1[(wr_b + 1) % 256]); end
        checks++; if (wdata1[(wr_b + 1) % 256] !== {32'd0, 32'hFFFF_FFF9}) begin failures++; $display("FAIL sub_data1: got %h required %h", wdata1[(wr_b + 1) % 256], {32'd0, 32'hFFFF_FFF9}); end
        checks++; if (bus1.ovf_cnt_o !== 16'd1) begin failures++; $display("FAIL sub_ovf: got %0d required 1", bus1.ovf_cnt_o); end
        checks++; if (bus1.err_o !== 1'b0) begin failures++; $display("FAIL sub_err: got %b required 0", bus1.err_o); end
    endtask

    task automatic test_satadd;
        logic [1:0]    modes [3];
        logic [MW-1:0] exp   [3];
        modes[0] = 2'b10; exp[0] = {32'd0, 32'hFFFF_FFFF};
        modes[1] = 2'b00; exp[1] = {32'd0, 32'h0000_0010};
        modes[2] = 2'b11; exp[2] = {32'd0, 32'h0000_0010};
        mem[20] = {32'h0000_0020, 32'hFFFF_FFF0};
        for (int k = 0; k < 3; k++) begin
            run(1, modes[k], 9'd20, 9'd20, 9'd400, 9'd400);
            checks++; if (wdata1[wr_b % 256] !== exp[k] || wr_cnt1 - wr_b !== 1) begin failures++; $display("FAIL sat_data mode%0d: got %h required %h", k, wdata1[wr_b % 256], exp[k]); end
            checks++; if (bus1.ovf_cnt_o !== 16'd1) begin failures++; $display("FAIL sat_ovf mode%0d: got %0d required 1", k, bus1.ovf_cnt_o); end
        end
    endtask

    task automatic test_cfg_err;
        run(1, 2'b00, 9'd5, 9'd4, 9'd256, 9'd256);
        checks++; if (bus1.err_o !== 1'b1) begin failures++; $display("FAIL cfg_err_flag: got %b required 1", bus1.err_o); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL cfg_err_latency: got %0d required 2", lat); end
        checks++; if (rd_cnt1 - rd_b !== 0 || wr_cnt1 - wr_b !== 0) begin failures++; $display("FAIL cfg_err_access: got rd=%0d wr=%0d required 0", rd_cnt1 - rd_b, wr_cnt1 - wr_b); end
        checks++; if (done_cnt1 - dn_b !== 1) begin failures++; $display("FAIL cfg_err_done: got %0d required 1", done_cnt1 - dn_b); end
        run(1, 2'b00, 9'd0, 9'd1, 9'd10, 9'd9);
        checks++; if (bus1.err_o !== 1'b1 || rd_cnt1 - rd_b !== 0) begin failures++; $display("FAIL cfg_err_wr_range: got err=%b rd=%0d required err=1 rd=0", bus1.err_o, rd_cnt1 - rd_b); end
    endtask

    task automatic test_exhaust;
        for (int i = 0; i < 6; i++) mem[30 + i] = {32'(i + 1), 32'(i * 10)};
        run(1, 2'b00, 9'd30, 9'd35, 9'd300, 9'd300);
        checks++; if (wr_cnt1 - wr_b !== 1 || waddr1[wr_b % 256] !== 9'd300) begin failures++; $display("FAIL exh_write: got count=%0d addr=%0d required 1 at 300", wr_cnt1 - wr_b, waddr1[wr_b % 256]); end
        checks++; if (wdata1[wr_b % 256] !== {32'd12, 32'd1}) begin failures++; $display("FAIL exh_data: got %h required %h", wdata1[wr_b % 256], {32'd12, 32'd1}); end
        checks++; if (bus1.err_o !== 1'b1) begin failures++; $display("FAIL exh_err: got %b required 1", bus1.err_o); end
        checks++; if (rd_cnt1 - rd_b > 4) begin failures++; $display("FAIL exh_reads: got %0d required at most 4", rd_cnt1 - rd_b); end
        checks++; if (tmo !== 1'b0 || done_cnt1 - dn_b !== 1) begin failures++; $display("FAIL exh_done: got %0d pulses required 1", done_cnt1 - dn_b); end
    endtask

    task automatic test_start_while_busy;
        snap(1);
        @(negedge clk);
        mode_v = 2'b00; rs_v = 9'd0; re_v = 9'd1; ws_v = 9'd256; we_v = 9'd256;
        start1 = 1'b1;
        lat = 0; tmo = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start1 = 1'b0;
                checks++; if (bus1.busy_o !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %b required 1", bus1.busy_o); end
            end
            if (i == 3) begin mode_v = 2'b01; rs_v = 9'd5; re_v = 9'd4; start1 = 1'b1; end
            if (i == 4) start1 = 1'b0;
            if (bus1.done_o) begin lat = i; tmo = 1'b0; break; end
        end
        repeat (5) @(negedge clk);
        checks++; if (lat !== 9) begin failures++; $display("FAIL busy_start_latency: got %0d required 9", lat); end
        checks++; if (wdata1[wr_b % 256] !== {32'd12, 32'd5} || wr_cnt1 - wr_b !== 1) begin failures++; $display("FAIL busy_start_data: got %h required %h", wdata1[wr_b % 256], {32'd12, 32'd5}); end
        checks++; if (bus1.err_o !== 1'b0 || rd_cnt1 - rd_b !== 2 || bus1.busy_o !== 1'b0) begin failures++; $display("FAIL busy_start_ignored: got err=%b rd=%0d busy=%b required 0/2/0", bus1.err_o, rd_cnt1 - rd_b, bus1.busy_o); end
    endtask

    task automatic test_reset_mid_run;
        int rd_at_rst;
        snap(1);
        @(negedge clk);
        mode_v = 2'b00; rs_v = 9'd0; re_v = 9'd1; ws_v = 9'd256; we_v = 9'd256;
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus1.rd_en_o, bus1.wr_en_o, bus1.busy_o, bus1.done_o, bus1.err_o, bus1.ovf_cnt_o,
             bus1.rd_addr_o, bus1.wr_addr_o, bus1.wr_data_o} !== '0) begin
            failures++; $display("FAIL mid_reset_outputs: busy=%b rd_addr=%0d required all zero", bus1.busy_o, bus1.rd_addr_o);
        end
        rd_at_rst = rd_cnt1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rd_cnt1 !== rd_at_rst || wr_cnt1 !== wr_b) begin failures++; $display("FAIL mid_reset_access: got rd=%0d wr=%0d extra, required none", rd_cnt1 - rd_at_rst, wr_cnt1 - wr_b); end
        run(1, 2'b00, 9'd0, 9'd1, 9'd256, 9'd256);
        checks++; if (tmo !== 1'b0 || wdata1[wr_b % 256] !== {32'd12, 32'd5} || bus1.err_o !== 1'b0) begin failures++; $display("FAIL post_reset_run: got %h err=%b required %h err=0", wdata1[wr_b % 256], bus1.err_o, {32'd12, 32'd5}); end
    endtask

    task automatic test_rd_lat3;
        run(3, 2'b00, 9'd0, 9'd1, 9'd256, 9'd256);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL lat3_timeout: done never seen"); end
        checks++; if (wr_cnt3 - wr_b !== 1 || waddr3[wr_b % 256] !== 9'd256) begin failures++; $display("FAIL lat3_write: got count=%0d addr=%0d required 1 at 256", wr_cnt3 - wr_b, waddr3[wr_b % 256]); end
        checks++; if (wdata3[wr_b % 256] !== {32'd12, 32'd5}) begin failures++; $display("FAIL lat3_data: got %h required %h", wdata3[wr_b % 256], {32'd12, 32'd5}); end
        checks++; if (lat !== 13) begin failures++; $display("FAIL lat3_latency: got %0d required 13", lat); end
        checks++; if (bus3.err_o !== 1'b0 || done_cnt3 - dn_b !== 1 || rd_cnt3 - rd_b !== 2) begin failures++; $display("FAIL lat3_status: got err=%b done=%0d rd=%0d required 0/1/2", bus3.err_o, done_cnt3 - dn_b, rd_cnt3 - rd_b); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        test_reset;
        test_basic_add;
        test_sub_odd;
        test_satadd;
        test_cfg_err;
        test_exhaust;
        test_start_while_busy;
        test_reset_mid_run;
        test_rd_lat3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
